// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory access unit (size codes, FSM states, timeout counter width)
package mem_access_pkg;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam int MEM_UNSIGNED_BIT = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data bus; master drives req/we/addr/be/wdata, slave returns ack/rdata
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ack, bus_rdata);
  modport slave (input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, lane-replicated store data, misalignment flag (request side) and extracted/extended load data (response side)
// ports: i_req_type/i_req_lo/i_wdata -> o_be/o_wdata/o_misaligned; i_rsp_type/i_rsp_lo/i_rdata -> o_rdata
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_req_type,
  input  logic [1:0]  i_req_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_rsp_type,
  input  logic [1:0]  i_rsp_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);
  logic [1:0]  w_sz;
  logic [1:0]  w_rsz;
  logic [31:0] w_sh;
  logic        w_sx;
  assign w_sz = i_req_type[1:0];
  assign w_rsz = i_rsp_type[1:0];
  assign o_be = w_sz == MEM_SIZE_BYTE ? 4'b0001 << i_req_lo :
                w_sz == MEM_SIZE_HALF ? 4'b0011 << i_req_lo : 4'b1111;
  assign o_wdata = w_sz == MEM_SIZE_BYTE ? {4{i_wdata[7:0]}} :
                   w_sz == MEM_SIZE_HALF ? {2{i_wdata[15:0]}} : i_wdata;
  // size code 3 is undefined and is rejected like a misaligned access
  assign o_misaligned = w_sz == MEM_SIZE_BYTE ? 1'b0 :
                        w_sz == MEM_SIZE_HALF ? i_req_lo[0] :
                        w_sz == MEM_SIZE_WORD ? |i_req_lo : 1'b1;
  assign w_sh = i_rdata >> {i_rsp_lo, 3'b000};
  assign w_sx = ~i_rsp_type[MEM_UNSIGNED_BIT];
  assign o_rdata = w_rsz == MEM_SIZE_BYTE ? {{24{w_sx & w_sh[7]}}, w_sh[7:0]} :
                   w_rsz == MEM_SIZE_HALF ? {{16{w_sx & w_sh[15]}}, w_sh[15:0]} : i_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns single-cycle CPU load/store requests into a req/ack bus transaction with sizing, stall and fault
// ports: clk, cpu_rst_n (async low), cpu_en, mem_ren/wen/type/addr/dout in, mem_din/stall/fault out, bus (master modport)
// MEM_ACCESS_STATS_EN adds stat_loads/stat_stores/stat_wait counters
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        cpu_rst_n,
  input  logic        cpu_en,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  mem_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_fault,
  mem_access_unit_if.master bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_wait
`endif
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_to;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_type;
  logic [1:0]  r_lo;
  logic [31:0] r_din;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_mis;
  logic        w_access;
  logic        w_illegal;
  logic        w_go;
  mem_lane_align u_align (
    .i_req_type  (mem_type),
    .i_req_lo    (mem_addr[1:0]),
    .i_wdata     (mem_dout),
    .i_rsp_type  (r_type),
    .i_rsp_lo    (r_lo),
    .i_rdata     (bus.bus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_rdata),
    .o_misaligned(w_mis)
  );
  assign w_access = cpu_en & (mem_ren ^ mem_wen);
  assign w_illegal = cpu_en & mem_ren & mem_wen;
  // gating with reset keeps stall low while reset is held even if the request inputs stay up
  assign w_go = cpu_rst_n & (r_state == ST_IDLE) & w_access & ~w_mis;
  assign mem_stall = w_go | (r_state == ST_REQ);
  assign mem_fault = ((r_state == ST_IDLE) & (w_illegal | (w_access & w_mis))) | ((r_state == ST_DONE) & r_to);
  assign mem_din = r_din;
  assign bus.bus_req = r_req;
  assign bus.bus_we = r_we;
  assign bus.bus_addr = r_addr;
  assign bus.bus_be = r_be;
  assign bus.bus_wdata = r_wdata;
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_to <= 1'b0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_type <= '0;
      r_lo <= '0;
      r_din <= '0;
`ifdef MEM_ACCESS_STATS_EN
      stat_loads <= '0;
      stat_stores <= '0;
      stat_wait <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_go) begin
          r_state <= ST_REQ;
          r_req <= 1'b1;
          r_we <= mem_wen;
          r_addr <= {mem_addr[31:2], 2'b00};
          r_be <= w_be;
          r_wdata <= w_wdata;
          r_type <= mem_type;
          r_lo <= mem_addr[1:0];
        end
        ST_REQ: begin
`ifdef MEM_ACCESS_STATS_EN
          stat_wait <= stat_wait + 32'd1;
`endif
          // an ack on the final timeout cycle still completes the access normally
          if (bus.bus_ack) begin
            if (!r_we) r_din <= w_rdata;
            r_cnt <= '0;
            r_req <= 1'b0;
            r_state <= ST_DONE;
`ifdef MEM_ACCESS_STATS_EN
            if (r_we) stat_stores <= stat_stores + 32'd1;
            else stat_loads <= stat_loads + 32'd1;
`endif
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_din <= '0;
            r_cnt <= '0;
            r_req <= 1'b0;
            r_to <= 1'b1;
            r_state <= ST_DONE;
          end else r_cnt <= r_cnt + CW'(1);
        end
        ST_DONE: begin
          r_to <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
